calc_op_sequencer: RTL and testbench

//  Sequences the 8-bit add/subtract calculator datapath: debounces the three active-low

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_op_sequencer_if.sv | 33 +++
 rtl/calc_op_sequencer_btn_debounce.sv | 58 +++++
 rtl/calc_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_calc_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the add/subtract calculator
//                sequencer: FSM state and pending-operation encodings plus
//                the button index map used by the debounce bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'b00,
        ST_OP_HELD = 2'b01,
        ST_RESULT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } op_t;

    localparam int BTN_PLUS  = 0;
    localparam int BTN_MINUS = 1;
    localparam int BTN_EQUAL = 2;
    localparam int NUM_BTNS  = 3;

endpackage
`default_nettype wire

// File: rtl/calc_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_op_sequencer_if
//  Description : Board-side bundle of the calculator sequencer: switch
//                operand, raw active-low buttons, and display/status outputs.
//                The master side drives operand and buttons; the slave side
//                (the sequencer) drives the display and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] operand;
    logic             plus_n;
    logic             minus_n;
    logic             equal_n;
    logic [WIDTH-1:0] disp_val;
    logic             disp_blank;
    logic             ovf;
    logic [1:0]       op_pending;
    logic [1:0]       state;

    modport master (
        output operand, plus_n, minus_n, equal_n,
        input  disp_val, disp_blank, ovf, op_pending, state
    );

    modport slave (
        input  operand, plus_n, minus_n, equal_n,
        output disp_val, disp_blank, ovf, op_pending, state
    );
endinterface
`default_nettype wire

// File: rtl/calc_op_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, stability counter and press-edge
//                detector for one active-low push button. The debounced level
//                only follows the synchronized input after DEBOUNCE_CYCLES
//                consecutive differing samples; a one-cycle pulse marks each
//                accepted press (1->0).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  raw_n,
    output logic level_n,
    output logic press_pulse
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= raw_n;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_n     <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync_q == level_n) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_n     <= sync_q;
                cnt         <= '0;
                press_pulse <= ~sync_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_op_sequencer
//  Description : Entry/operator/result FSM of the 8-bit add/subtract
//                calculator. Debounces the three operator buttons, keeps the
//                accumulator, pending operation, operand snapshot and
//                overflow flag, and drives the registered display outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    calc_op_sequencer_if.slave   bus
);
    logic [NUM_BTNS-1:0] raw_n;
    logic [NUM_BTNS-1:0] level_n;
    logic [NUM_BTNS-1:0] pulse;

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] snap_q;
    logic             ovf_q;
    logic [WIDTH-1:0] disp_val_q;
    logic             disp_blank_q;

    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      diff;
    logic [WIDTH:0]      alu;
    logic [NUM_BTNS-1:0] held_mask;
    logic                op_btn_low;
    logic                go_plus;
    logic                go_minus;
    logic                go_equal;
    logic                any_pulse;
    op_t                 new_op;

    assign raw_n[BTN_PLUS]  = bus.plus_n;
    assign raw_n[BTN_MINUS] = bus.minus_n;
    assign raw_n[BTN_EQUAL] = bus.equal_n;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .rst         (rst),
            .raw_n       (raw_n[i]),
            .level_n     (level_n[i]),
            .press_pulse (pulse[i])
        );
    end

    // Fixed priority plus > minus > equal; losers in the same cycle are dropped.
    assign go_plus   = pulse[BTN_PLUS];
    assign go_minus  = pulse[BTN_MINUS] & ~pulse[BTN_PLUS];
    assign go_equal  = pulse[BTN_EQUAL] & ~pulse[BTN_PLUS] & ~pulse[BTN_MINUS];
    assign any_pulse = |pulse;
    assign new_op    = go_plus ? OP_ADD : OP_SUB;

    // Top bit of sum is carry-out; top bit of diff is the borrow (operand > acc).
    assign sum  = {1'b0, acc_q} + {1'b0, bus.operand};
    assign diff = {1'b0, acc_q} - {1'b0, bus.operand};

    // Result of applying the pending operation, as {ovf, acc}.
    always_comb begin
        alu = {ovf_q, acc_q};
        case (op_q)
            OP_ADD:  alu = sum;
            OP_SUB:  alu = diff;
            default: alu = {ovf_q, acc_q};
        endcase
    end

    // Select the debounced button belonging to the pending operation for blanking.
    always_comb begin
        held_mask = '0;
        if (op_q == OP_ADD) held_mask[BTN_PLUS]  = 1'b1;
        if (op_q == OP_SUB) held_mask[BTN_MINUS] = 1'b1;
    end
    assign op_btn_low = |(held_mask & ~level_n);

    // Calculator FSM with its datapath registers and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ENTRY;
            op_q         <= OP_NONE;
            acc_q        <= '0;
            snap_q       <= '0;
            ovf_q        <= 1'b0;
            disp_val_q   <= '0;
            disp_blank_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    disp_val_q   <= bus.operand;
                    disp_blank_q <= 1'b0;
                    if (go_plus || go_minus) begin
                        acc_q   <= bus.operand;
                        op_q    <= new_op;
                        state_q <= ST_OP_HELD;
                    end else if (go_equal) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        op_q    <= OP_NONE;
                        snap_q  <= bus.operand;
                        state_q <= ST_RESULT;
                    end
                end
                ST_OP_HELD: begin
                    disp_val_q   <= bus.operand;
                    disp_blank_q <= op_btn_low;
                    if (go_equal) begin
                        acc_q   <= alu[WIDTH-1:0];
                        ovf_q   <= alu[WIDTH];
                        op_q    <= OP_NONE;
                        snap_q  <= bus.operand;
                        state_q <= ST_RESULT;
                    end else if (go_plus || go_minus) begin
                        acc_q <= alu[WIDTH-1:0];
                        ovf_q <= alu[WIDTH];
                        op_q  <= new_op;
                    end
                end
                ST_RESULT: begin
                    disp_val_q   <= acc_q;
                    disp_blank_q <= 1'b0;
                    if (go_plus || go_minus) begin
                        op_q    <= new_op;
                        state_q <= ST_OP_HELD;
                    end else if (!any_pulse && (bus.operand != snap_q)) begin
                        state_q <= ST_ENTRY;
                    end
                end
                default: begin
                    state_q <= ST_ENTRY;
                end
            endcase
        end
    end

    assign bus.disp_val   = disp_val_q;
    assign bus.disp_blank = disp_blank_q;
    assign bus.ovf        = ovf_q;
    assign bus.op_pending = op_q;
    assign bus.state      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_op_sequencer
//  Description : Self-checking bench for calc_op_sequencer (WIDTH=8,
//                DEBOUNCE_CYCLES=4). Expected results are queued when the
//                equal press is driven and compared when RESULT shows them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;
    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    localparam logic [1:0] S_ENTRY = 2'b00;
    localparam logic [1:0] S_OP    = 2'b01;
    localparam logic [1:0] S_RES   = 2'b10;
    localparam logic [1:0] O_NONE  = 2'b00;
    localparam logic [1:0] O_ADD   = 2'b01;
    localparam logic [1:0] O_SUB   = 2'b10;

    localparam int B_PLUS  = 0;
    localparam int B_MINUS = 1;
    localparam int B_EQUAL = 2;

    typedef struct packed {
        logic [7:0] val;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    bit   ok;

    calc_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    calc_op_sequencer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_apply(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        exp_t r;
        int   s;
        if (op == O_ADD) begin
            s     = int'(a) + int'(b);
            r.val = 8'(s);
            r.ovf = (s > 255);
        end else begin
            r.val = a - b;
            r.ovf = (b > a);
        end
        return r;
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(int idx, logic v);
        case (idx)
            B_PLUS:  bus.plus_n  = v;
            B_MINUS: bus.minus_n = v;
            default: bus.equal_n = v;
        endcase
    endtask

    task automatic press(int idx);
        set_btn(idx, 1'b0);
        cyc(8);
        set_btn(idx, 1'b1);
        cyc(8);
    endtask

    task automatic do_reset(logic [7:0] op);
        rst         = 1'b1;
        bus.operand = op;
        bus.plus_n  = 1'b1;
        bus.minus_n = 1'b1;
        bus.equal_n = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_state(logic [1:0] s, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.state === s) begin
                found = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        do_reset(8'h25);
        checks++; if (bus.disp_val !== 8'h00) begin errors++; $display("FAIL reset_disp: got %h required 00", bus.disp_val); end
        checks++; if (bus.op_pending !== O_NONE) begin errors++; $display("FAIL reset_op: got %b required %b", bus.op_pending, O_NONE); end
        cyc(1);
        checks++; if (bus.disp_val !== 8'h25) begin errors++; $display("FAIL entry_disp: got %h required 25", bus.disp_val); end
        checks++; if (bus.disp_blank !== 1'b0) begin errors++; $display("FAIL entry_blank: got %b required 0", bus.disp_blank); end
        checks++; if (bus.state !== S_ENTRY) begin errors++; $display("FAIL entry_state: got %b required %b", bus.state, S_ENTRY); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL entry_ovf: got %b required 0", bus.ovf); end
    endtask

    task automatic test_add_sub();
        do_reset(8'd200);
        cyc(1);
        press(B_PLUS);
        checks++; if (bus.op_pending !== O_ADD) begin errors++; $display("FAIL add_op: got %b required %b", bus.op_pending, O_ADD); end
        bus.operand = 8'd100;
        sb.push_back(model_apply(O_ADD, 8'd200, 8'd100));
        press(B_EQUAL);
        wait_state(S_RES, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_wait: state %b required %b", bus.state, S_RES); end
        else begin
            e = sb.pop_front();
            if (bus.disp_val !== e.val || bus.ovf !== e.ovf) begin
                errors++; $display("FAIL add_result: got %h/%b required %h/%b", bus.disp_val, bus.ovf, e.val, e.ovf);
            end
        end
        bus.operand = 8'd50;
        cyc(3);
        checks++; if (bus.state !== S_ENTRY) begin errors++; $display("FAIL result_leave: got %b required %b", bus.state, S_ENTRY); end
        press(B_MINUS);
        checks++; if (bus.op_pending !== O_SUB) begin errors++; $display("FAIL sub_op: got %b required %b", bus.op_pending, O_SUB); end
        bus.operand = 8'd20;
        sb.push_back(model_apply(O_SUB, 8'd50, 8'd20));
        press(B_EQUAL);
        wait_state(S_RES, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sub_wait: state %b required %b", bus.state, S_RES); end
        else begin
            e = sb.pop_front();
            if (bus.disp_val !== e.val || bus.ovf !== e.ovf) begin
                errors++; $display("FAIL sub_result: got %h/%b required %h/%b", bus.disp_val, bus.ovf, e.val, e.ovf);
            end
        end
    endtask

    task automatic test_borrow();
        do_reset(8'd10);
        cyc(1);
        press(B_MINUS);
        bus.operand = 8'd30;
        sb.push_back(model_apply(O_SUB, 8'd10, 8'd30));
        press(B_EQUAL);
        wait_state(S_RES, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL borrow_wait: state %b required %b", bus.state, S_RES); end
        else begin
            e = sb.pop_front();
            if (bus.disp_val !== e.val || bus.ovf !== e.ovf) begin
                errors++; $display("FAIL borrow_result: got %h/%b required %h/%b", bus.disp_val, bus.ovf, e.val, e.ovf);
            end
        end
        bus.operand = 8'h07;
        cyc(3);
        checks++; if (bus.state !== S_ENTRY) begin errors++; $display("FAIL borrow_leave: got %b required %b", bus.state, S_ENTRY); end
        checks++; if (bus.disp_val !== 8'h07) begin errors++; $display("FAIL borrow_entry_disp: got %h required 07", bus.disp_val); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL borrow_ovf_kept: got %b required 1", bus.ovf); end
    endtask

    task automatic test_debounce();
        bit stayed;
        do_reset(8'h11);
        cyc(2);
        bus.plus_n = 1'b0;
        cyc(3);
        bus.plus_n = 1'b1;
        stayed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.state !== S_ENTRY) stayed = 1'b0;
        end
        checks++; if (!stayed) begin errors++; $display("FAIL glitch_ignored: state %b required %b", bus.state, S_ENTRY); end
        bus.plus_n = 1'b0;
        cyc(6);
        checks++; if (bus.state !== S_ENTRY) begin errors++; $display("FAIL press_edge6: got %b required %b", bus.state, S_ENTRY); end
        cyc(1);
        checks++; if (bus.state !== S_OP) begin errors++; $display("FAIL press_edge7: got %b required %b", bus.state, S_OP); end
        checks++; if (bus.op_pending !== O_ADD) begin errors++; $display("FAIL press_op: got %b required %b", bus.op_pending, O_ADD); end
        cyc(2);
        checks++; if (bus.disp_blank !== 1'b1) begin errors++; $display("FAIL held_blank: got %b required 1", bus.disp_blank); end
        bus.plus_n = 1'b1;
        cyc(10);
        checks++; if (bus.disp_blank !== 1'b0 || bus.disp_val !== 8'h11) begin
            errors++; $display("FAIL released_disp: got %b/%h required 0/11", bus.disp_blank, bus.disp_val);
        end
    endtask

    task automatic test_priority_chain();
        exp_t mid;
        do_reset(8'd5);
        cyc(1);
        bus.plus_n  = 1'b0;
        bus.minus_n = 1'b0;
        cyc(8);
        checks++; if (bus.op_pending !== O_ADD) begin errors++; $display("FAIL priority_op: got %b required %b", bus.op_pending, O_ADD); end
        bus.plus_n  = 1'b1;
        bus.minus_n = 1'b1;
        cyc(8);
        bus.operand = 8'd3;
        press(B_PLUS);
        checks++; if (bus.state !== S_OP) begin errors++; $display("FAIL chain_state: got %b required %b", bus.state, S_OP); end
        mid = model_apply(O_ADD, 8'd5, 8'd3);
        bus.operand = 8'd2;
        sb.push_back(model_apply(O_ADD, mid.val, 8'd2));
        press(B_EQUAL);
        wait_state(S_RES, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL chain_wait: state %b required %b", bus.state, S_RES); end
        else begin
            e = sb.pop_front();
            if (bus.disp_val !== e.val || bus.ovf !== e.ovf) begin
                errors++; $display("FAIL chain_result: got %h/%b required %h/%b", bus.disp_val, bus.ovf, e.val, e.ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(8'hF0);
        cyc(1);
        press(B_PLUS);
        bus.operand = 8'h50;
        sb.push_back(model_apply(O_ADD, 8'hF0, 8'h50));
        press(B_EQUAL);
        wait_state(S_RES, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pre_reset_wait: state %b required %b", bus.state, S_RES); end
        else begin
            e = sb.pop_front();
            if (bus.disp_val !== e.val || bus.ovf !== e.ovf) begin
                errors++; $display("FAIL pre_reset_result: got %h/%b required %h/%b", bus.disp_val, bus.ovf, e.val, e.ovf);
            end
        end
        bus.plus_n = 1'b0;
        cyc(10);
        checks++; if (bus.state !== S_OP) begin errors++; $display("FAIL pre_reset_state: got %b required %b", bus.state, S_OP); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.state !== S_ENTRY) begin errors++; $display("FAIL async_state: got %b required %b", bus.state, S_ENTRY); end
        checks++; if (bus.op_pending !== O_NONE) begin errors++; $display("FAIL async_op: got %b required %b", bus.op_pending, O_NONE); end
        checks++; if (bus.disp_val !== 8'h00) begin errors++; $display("FAIL async_disp: got %h required 00", bus.disp_val); end
        checks++; if (bus.ovf !== 1'b0 || bus.disp_blank !== 1'b0) begin
            errors++; $display("FAIL async_flags: got ovf %b blank %b required 0/0", bus.ovf, bus.disp_blank);
        end
        bus.plus_n = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.operand = '0;
        bus.plus_n  = 1'b1;
        bus.minus_n = 1'b1;
        bus.equal_n = 1'b1;
        test_reset();
        test_add_sub();
        test_borrow();
        test_debounce();
        test_priority_chain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
